// File: rtl/tree_traversal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tree_traversal_ctrl
//  Purpose  : Walks a decision tree held in a single-port node memory
//             (64-bit node words, 1-cycle registered read). It latches a
//             feature vector on start, descends from the root node and
//             reports the class of the leaf it reaches. A malformed tree is
//             flagged as a fault: a child pointer out of range, or a walk
//             that reaches MAX_DEPTH nodes without finding a leaf.
//  Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//             start, features     - inference request, 8 x FEAT_W feature vector
//             mem_addr, mem_data  - node address out (registered), node word in
//             busy, done          - walk in progress, one-cycle completion pulse
//             class_out, error    - leaf class, fault flag (held until next start)
//             depth               - nodes visited in the last inference
//  Options  : TREE_NODE_CHECK_EN  - when defined, compares each node's node_id
//                                   field with the address that fetched it
//  Revision : 1.0 - initial release
// ============================================================================
module tree_traversal_ctrl #(
  parameter int NUM_NODES = 173,
  parameter int ROOT_ADDR = 0,
  parameter int MAX_DEPTH = 32,
  parameter int FEAT_W    = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*FEAT_W-1:0] features,
  output logic [7:0]          mem_addr,
  input  logic [63:0]         mem_data,
  output logic                busy,
  output logic                done,
  output logic [7:0]          class_out,
  output logic                error,
  output logic [5:0]          depth
);

  localparam logic [7:0] c_root_addr  = 8'(ROOT_ADDR);
  localparam logic [8:0] c_node_limit = 9'(NUM_NODES);
  localparam logic [6:0] c_max_depth  = 7'(MAX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [8*FEAT_W-1:0] r_feat, w_feat_nxt;
  logic [7:0]          w_addr_nxt;
  logic [7:0]          w_class_nxt;
  logic                w_error_nxt;
  logic [5:0]          w_depth_nxt;

  // Node word fields
  logic [2:0]        w_fid;
  logic [FEAT_W-1:0] w_thr;
  logic [7:0]        w_right;
  logic [7:0]        w_left;
  logic [7:0]        w_type;
  logic              w_leaf;
  logic [FEAT_W-1:0] w_feat_sel;
  logic [7:0]        w_child;
  logic [6:0]        w_depth_inc;
  logic              w_id_mismatch;

  assign w_fid   = mem_data[55:53];
  assign w_thr   = mem_data[52:26];
  assign w_right = mem_data[25:18];
  assign w_left  = mem_data[17:10];
  assign w_type  = mem_data[9:2];

  // A node with no children is a leaf even if its type byte says otherwise.
  assign w_leaf = (w_type == 8'h01) || ((w_left == 8'h00) && (w_right == 8'h00));

`ifdef TREE_NODE_CHECK_EN
  // mem_addr is stable from WAIT through EVAL, so it is still the address
  // that fetched the word now on mem_data.
  assign w_id_mismatch = (mem_data[63:56] != mem_addr);
  logic unused_node_bits;
  assign unused_node_bits = ^mem_data[1:0];
`else
  assign w_id_mismatch = 1'b0;
  logic unused_node_bits;
  assign unused_node_bits = ^{mem_data[63:56], mem_data[1:0]};
`endif

  // Select the latched feature named by the node
  always_comb begin
    w_feat_sel = '0;
    for (int f = 0; f < 8; f++) begin
      if (w_fid == 3'(f)) begin
        w_feat_sel = r_feat[f*FEAT_W +: FEAT_W];
      end
    end
  end

  assign w_child     = (w_feat_sel <= w_thr) ? w_left : w_right;
  assign w_depth_inc = {1'b0, depth} + 7'd1;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_feat    <= '0;
      mem_addr  <= 8'h00;
      class_out <= 8'h00;
      error     <= 1'b0;
      depth     <= 6'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_feat    <= w_feat_nxt;
      mem_addr  <= w_addr_nxt;
      class_out <= w_class_nxt;
      error     <= w_error_nxt;
      depth     <= w_depth_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_feat_nxt  = r_feat;
    w_addr_nxt  = mem_addr;
    w_class_nxt = class_out;
    w_error_nxt = error;
    w_depth_nxt = depth;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_feat_nxt  = features;
          w_addr_nxt  = c_root_addr;
          w_depth_nxt = 6'd0;
          w_error_nxt = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        // The visited count grows on every evaluated node, faulty or not.
        w_depth_nxt = w_depth_inc[5:0];
        w_state_nxt = S_DONE;
        if (w_leaf) begin
          w_class_nxt = w_thr[7:0];
        end else if (w_id_mismatch) begin
          w_error_nxt = 1'b1;
        end else if (w_depth_inc == c_max_depth) begin
          w_error_nxt = 1'b1;
        end else if ({1'b0, w_child} >= c_node_limit) begin
          w_error_nxt = 1'b1;
        end else begin
          w_addr_nxt  = w_child;
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
